icache_burst: RTL and testbench
===============================

ICACHE_BURST -- requirements
Module: icache_burst

Interface
REQ-001 SHALL have parameter LINES, default 64, meaning number of cache lines (power of 2, >=2).
REQ-002 SHALL have parameter WORDS, default 4, meaning 32-bit words per line (power of 2, >=2).
REQ-003 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-004 SHALL have port clk_in  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_in  input  1  invalidate all lines.
REQ-007 SHALL have port inst_read_in  input  1  fetch request from IF.
REQ-008 SHALL have port inst_address_in  input  ADDR_W  fetch byte address (bits [1:0] ignored).
REQ-009 SHALL have port inst_enable_out  output  1  inst_data_out valid this cycle.
REQ-010 SHALL have port inst_data_out  output  32  fetched instruction.
REQ-011 SHALL have port mem_req_out  output  1  one-cycle word read request to memory controller.
REQ-012 SHALL have port mem_addr_out  output  ADDR_W  word-aligned read address.
REQ-013 SHALL have port mem_busy_in  input  1  controller cannot accept a request.
REQ-014 SHALL have port mem_valid_in  input  1  mem_data_in holds the requested word.
REQ-015 SHALL have port mem_data_in  input  32  returned word.

Function
REQ-016 SHALL split the address as offset=[log2(WORDS)+1:2], index=next log2(LINES) bits, tag=remaining upper bits.
REQ-017 SHALL be direct-mapped; per line: valid bit, tag, WORDS data words.
REQ-018 SHALL use FSM states IDLE and FILL.
REQ-019 In IDLE with inst_read_in=1 and valid&&tag match: SHALL assert inst_enable_out and drive the stored word combinationally in the same cycle (0-cycle hit).
REQ-020 In IDLE with inst_read_in=1 and miss: SHALL latch tag/index, clear word counter k, go to FILL next edge; inst_enable_out=0.
REQ-021 In FILL, no outstanding request and mem_busy_in=0: SHALL pulse mem_req_out one cycle with mem_addr_out={tag,index,k,2'b00} and set outstanding.
REQ-022 SHALL keep at most one outstanding request; mem_req_out=0 while outstanding or mem_busy_in=1.
REQ-023 On mem_valid_in in FILL: SHALL write mem_data_in to word k of the line buffer, clear outstanding, increment k.
REQ-024 Critical-word forward: on mem_valid_in whose word address equals inst_address_in (inst_read_in=1), SHALL assert inst_enable_out with mem_data_in that cycle.
REQ-025 After word WORDS-1 is written: SHALL set line valid and tag on that edge and return to IDLE; line hits from the next cycle.
REQ-026 Fill SHALL run in address order from word 0 to WORDS-1 regardless of requested offset; k wraps to 0 on completion.
REQ-027 Line valid bit SHALL be cleared on the edge entering FILL; a partly filled line never hits.
REQ-028 IF address change or inst_read_in drop during FILL SHALL NOT abort the fill; no hits serviced in FILL except REQ-024.
REQ-029 flush_in=1 SHALL clear all valid bits at that edge, abort any fill (FILL->IDLE, outstanding cleared, late mem_valid_in ignored), and suppress hits that cycle.
REQ-030 inst_enable_out=0 and inst_data_out=0 whenever not hitting or forwarding.

Reset
REQ-031 rst_in=1 SHALL clear all valid bits, state=IDLE, k=0, outstanding=0 at that edge; priority over flush_in and mem_valid_in.
REQ-032 While rst_in=1: inst_enable_out=0, inst_data_out=0, mem_req_out=0, mem_addr_out=0.
REQ-033 Reset mid-fill SHALL discard the fill; the line stays invalid.

Verification (LINES=64, WORDS=4)
REQ-034 Reset, read 0x104 -> miss; requests to 0x100,0x104,0x108,0x10C in order; inst_enable_out=1 with data on the 0x104 return cycle.
REQ-035 After REQ-034, read 0x108 -> inst_enable_out=1 same cycle, no mem_req_out.
REQ-036 Read 0x504 (index 16, tag 1) after 0x104 filled -> miss, refill evicts; a re-read of 0x104 then misses.
REQ-037 mem_busy_in held 5 cycles in FILL -> no mem_req_out until busy drops; still one outstanding at most.
REQ-038 flush_in after word 1 of a fill -> FSM IDLE, remaining mem_valid_in ignored, re-read of same address misses.
REQ-039 rst_in asserted mid-fill -> all outputs 0 next cycle, prior valid lines miss.

Source files
------------

// File: rtl/icache_burst_if.sv
// icache_burst_if: fetch-side and memory-side handshake bundle for icache_burst
interface icache_burst_if #(parameter int ADDR_W = 32);
  logic              inst_read_in;
  logic [ADDR_W-1:0] inst_address_in;
  logic              inst_enable_out;
  logic [31:0]       inst_data_out;
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_busy_in;
  logic              mem_valid_in;
  logic [31:0]       mem_data_in;
  modport slave (
    input  inst_read_in, inst_address_in, mem_busy_in, mem_valid_in, mem_data_in,
    output inst_enable_out, inst_data_out, mem_req_out, mem_addr_out
  );
  modport master (
    output inst_read_in, inst_address_in, mem_busy_in, mem_valid_in, mem_data_in,
    input  inst_enable_out, inst_data_out, mem_req_out, mem_addr_out
  );
endinterface

// File: rtl/icache_burst.sv
// icache_burst: direct-mapped instruction cache, word-by-word line fill with critical-word forward
module icache_burst #(
  parameter int LINES  = 64,
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic flush_in,
  icache_burst_if.slave bus
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - OW - IW - 2;
  typedef enum logic {IDLE, FILL} state_t;
  state_t          state_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   tag_q [LINES];
  logic [31:0]     data_q [LINES][WORDS];
  logic [TW-1:0]   ftag_q;
  logic [IW-1:0]   fidx_q;
  logic [OW-1:0]   k_q;
  logic            out_q;
  logic [TW-1:0]   a_tag;
  logic [IW-1:0]   a_idx;
  logic [OW-1:0]   a_off;
  logic            match, hit, take, fwd, req, unused;
  assign a_tag  = bus.inst_address_in[ADDR_W-1 -: TW];
  assign a_idx  = bus.inst_address_in[OW+2 +: IW];
  assign a_off  = bus.inst_address_in[2 +: OW];
  assign unused = &{1'b0, bus.inst_address_in[1:0]};
  assign match  = valid_q[a_idx] && tag_q[a_idx] == a_tag;
  assign hit    = !rst_in && !flush_in && state_q == IDLE && bus.inst_read_in && match;
  assign take   = state_q == FILL && out_q && bus.mem_valid_in;
  // returning word is forwarded only when it is exactly the word the fetch stage is waiting on
  assign fwd    = !rst_in && !flush_in && take && bus.inst_read_in &&
                  bus.inst_address_in[ADDR_W-1:2] == {ftag_q, fidx_q, k_q};
  assign req    = !rst_in && !flush_in && state_q == FILL && !out_q && !bus.mem_busy_in;
  assign bus.inst_enable_out = hit || fwd;
  assign bus.inst_data_out   = hit ? data_q[a_idx][a_off] : fwd ? bus.mem_data_in : '0;
  assign bus.mem_req_out     = req;
  assign bus.mem_addr_out    = req ? {ftag_q, fidx_q, k_q, 2'b00} : '0;
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      valid_q <= '0;
      state_q <= IDLE;
      k_q     <= '0;
      out_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.inst_read_in && !match) begin
        ftag_q         <= a_tag;
        fidx_q         <= a_idx;
        k_q            <= '0;
        valid_q[a_idx] <= 1'b0;
        state_q        <= FILL;
      end
    end else begin
      if (req) out_q <= 1'b1;
      if (take) begin
        data_q[fidx_q][k_q] <= bus.mem_data_in;
        out_q               <= 1'b0;
        k_q                 <= k_q + 1'b1;
        if (&k_q) begin
          valid_q[fidx_q] <= 1'b1;
          tag_q[fidx_q]   <= ftag_q;
          state_q         <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_burst.sv
// tb_icache_burst: directed scoreboard bench with a fixed-latency word memory model
module tb_icache_burst;
  logic clk = 1'b0;
  logic rst, flush;
  icache_burst_if #(.ADDR_W(32)) bus();
  icache_burst #(.LINES(64), .WORDS(4), .ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, lat = 0, busy_cnt = 0, nvalid = 0;
  logic [31:0] paddr = '0;
  logic [31:0] addr_q[$], data_q[$];
  logic        en_o, req_o;
  logic [31:0] dat_o, addr_o;
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one clock: drive inputs just after the edge, memory answers two cycles after each request
  task automatic cyc(input logic rd, input logic [31:0] a, input logic fl, input logic rs);
    logic pend;
    @(posedge clk); #1;
    rst = rs; flush = fl;
    bus.inst_read_in = rd; bus.inst_address_in = a;
    bus.mem_valid_in = (lat == 1);
    bus.mem_data_in  = (lat == 1) ? mdata(paddr) : 32'hDEAD_BEEF;
    if (lat == 1) nvalid++;
    if (lat > 0) lat--;
    bus.mem_busy_in = busy_cnt > 0;
    if (busy_cnt > 0) busy_cnt--;
    pend = lat > 0 || bus.mem_valid_in;
    #1;
    en_o = bus.inst_enable_out; dat_o = bus.inst_data_out;
    req_o = bus.mem_req_out; addr_o = bus.mem_addr_out;
    if (req_o) begin
      chk("req_while_busy", bus.mem_busy_in, 0);
      chk("one_outstanding", pend, 0);
      if (addr_q.size() > 0) chk("req_addr", addr_o, addr_q.pop_front());
      else chk("req_unexpected", req_o, 0);
      lat = 2; paddr = addr_o;
    end
    if (en_o) begin
      if (data_q.size() > 0) chk("fetch_data", dat_o, data_q.pop_front());
      else chk("fetch_unexpected", en_o, 0);
    end else chk("data_zero", dat_o, 0);
  endtask
  task automatic fill_read(input logic [31:0] a, input int busy);
    int   first_req = -1;
    logic got = 1'b0;
    for (int i = 0; i < 4; i++) addr_q.push_back({a[31:4], 4'h0} + 32'(i * 4));
    data_q.push_back(mdata(a));
    cyc(1, a, 0, 0);
    chk("miss_en", en_o, 0);
    busy_cnt = busy;
    for (int i = 0; i < 60 && !got; i++) begin
      cyc(1, a, 0, 0);
      if (req_o && first_req < 0) first_req = i;
      got = en_o;
    end
    chk("fwd_seen", got, 1);
    chk("fwd_on_valid", bus.mem_valid_in, 1);
    if (busy > 0) chk("busy_hold", first_req, busy);
    for (int i = 0; i < 60 && (addr_q.size() > 0 || lat > 0); i++) cyc(0, a, 0, 0);
    chk("fill_done", addr_q.size(), 0);
  endtask
  task automatic hit(input logic [31:0] a);
    data_q.push_back(mdata(a));
    cyc(1, a, 0, 0);
    chk("hit_en", en_o, 1);
    chk("hit_noreq", req_o, 0);
  endtask
  initial begin
    int nv0;
    rst = 1'b1; flush = 1'b0;
    bus.inst_read_in = 1'b0; bus.inst_address_in = '0;
    bus.mem_busy_in = 1'b0; bus.mem_valid_in = 1'b0; bus.mem_data_in = '0;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 32'h108, 0, 1);
      chk("rst_en", en_o, 0); chk("rst_data", dat_o, 0);
      chk("rst_req", req_o, 0); chk("rst_addr", addr_o, 0);
    end
    fill_read(32'h104, 0);
    hit(32'h108); hit(32'h100); hit(32'h10C); hit(32'h104);
    fill_read(32'h504, 0);
    hit(32'h500);
    fill_read(32'h104, 0);
    hit(32'h10C);
    fill_read(32'h40C, 5);
    hit(32'h400);
    // flush with word 2 of the fill still outstanding
    addr_q.push_back(32'h200); addr_q.push_back(32'h204); addr_q.push_back(32'h208);
    data_q.push_back(mdata(32'h204));
    nv0 = nvalid;
    cyc(1, 32'h204, 0, 0);
    chk("fl_miss_en", en_o, 0);
    for (int i = 0; i < 30 && nvalid < nv0 + 2; i++) cyc(1, 32'h204, 0, 0);
    chk("fl_fwd_done", data_q.size(), 0);
    cyc(0, 32'h204, 0, 0);
    chk("fl_pre_req", req_o, 1);
    cyc(0, 32'h204, 1, 0);
    chk("fl_en", en_o, 0); chk("fl_req", req_o, 0);
    cyc(0, 32'h204, 0, 0);
    chk("late_valid", bus.mem_valid_in, 1); chk("late_en", en_o, 0); chk("late_req", req_o, 0);
    fill_read(32'h204, 0);
    fill_read(32'h108, 0);
    // reset in the middle of a fill
    addr_q.push_back(32'h300);
    cyc(1, 32'h304, 0, 0);
    chk("rf_miss_en", en_o, 0);
    cyc(1, 32'h304, 0, 0);
    chk("rf_req", req_o, 1);
    cyc(1, 32'h108, 0, 1);
    chk("mr_en", en_o, 0); chk("mr_req", req_o, 0); chk("mr_addr", addr_o, 0);
    cyc(0, 32'h108, 0, 0);
    chk("pr_en", en_o, 0); chk("pr_req", req_o, 0); chk("pr_addr", addr_o, 0);
    fill_read(32'h108, 0);
    chk("queues_empty", addr_q.size() + data_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
